// File: rtl/twiddle_stream_generator.sv
// twiddle_stream_generator: streams one FFT stage's twiddle factors in butterfly order,
// derived from a quarter-wave sine table by symmetry.
module twiddle_stream_generator #(
    parameter int BIT_WIDTH = 32,
    parameter int DECIMAL_POINT = 16,
    parameter int SIZE_FFT = 8,
    localparam int L = $clog2(SIZE_FFT),
    localparam int IW = (L > 1) ? L - 1 : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [L-1:0]         req_stage,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [BIT_WIDTH-1:0] resp_real,
    output logic [BIT_WIDTH-1:0] resp_imag,
    output logic [IW-1:0]        resp_idx,
    output logic                 resp_last
);
    localparam int QN = SIZE_FFT / 4;
    localparam logic [IW-1:0] JMAX = IW'(SIZE_FFT / 2 - 1);
    localparam logic [L-1:0] SMAX = L'(L - 1);

    function automatic logic [(QN+1)*BIT_WIDTH-1:0] build_q();
        logic [(QN+1)*BIT_WIDTH-1:0] v;
        v = '0;
        for (int i = 1; i < QN; i++)
            v[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'($rtoi($sin(2.0 * 3.141592653589793 * i / SIZE_FFT) * (2.0 ** DECIMAL_POINT)));
        // the peak is set exactly so rounding in $sin can never truncate it to 2^DP-1
        v[QN*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(1) << DECIMAL_POINT;
        return v;
    endfunction

    localparam logic [(QN+1)*BIT_WIDTH-1:0] Q = build_q();

    function automatic logic [BIT_WIDTH-1:0] sine(input logic [L-1:0] u);
        int quad, r;
        logic [BIT_WIDTH-1:0] m;
        quad = int'(u) / QN;
        r = int'(u) % QN;
        m = Q[((quad == 1 || quad == 3) ? QN - r : r) * BIT_WIDTH +: BIT_WIDTH];
        return (quad >= 2) ? -m : m;
    endfunction

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_q, state_d;
    logic [L-1:0] stage_q, stage_d, bs, t;
    logic [IW-1:0] j_q, j_d, bj;
    logic [BIT_WIDTH-1:0] real_q, real_d, imag_q, imag_d;
    logic last_q, last_d, load;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d = j_q;
        real_d = real_q;
        imag_d = imag_q;
        last_d = last_q;
        load = 1'b0;
        bs = stage_q;
        bj = j_q + IW'(1);
        if (state_q == IDLE && req_val) begin
            state_d = STREAM;
            bs = (req_stage > SMAX) ? SMAX : req_stage;
            bj = '0;
            stage_d = bs;
            load = 1'b1;
        end else if (state_q == STREAM && resp_rdy) begin
            if (j_q == JMAX) state_d = IDLE;
            else load = 1'b1;
        end
        t = (L'(bj) & ((L'(1) << bs) - L'(1))) << (SMAX - bs);
        if (load) begin
            j_d = bj;
            real_d = sine(t + L'(QN));
            imag_d = -sine(t);
            last_d = (bj == JMAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            j_q <= '0;
            real_q <= '0;
            imag_q <= '0;
            last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q <= j_d;
            real_q <= real_d;
            imag_q <= imag_d;
            last_q <= last_d;
        end
    end

    assign req_rdy = (state_q == IDLE);
    assign resp_val = (state_q == STREAM);
    assign resp_real = real_q;
    assign resp_imag = imag_q;
    assign resp_idx = j_q;
    assign resp_last = last_q;
endmodule
